ram_stream_reader: RTL and testbench

- Read-side controller for a true-dual-port block RAM. A writer fills the RAM through one port; this block drains a frame through the other port.
- On a start command it issues sequential reads from a start address for a given length, wrapping modulo RAM_LEN (ring-buffer addressing).
- It presents the data as a valid/ready stream with last-beat marking.
- It hides the RAM's 1-cycle read latency (no output register) behind a 2-entry output FIFO, so it sustains 1 beat/clk under continuous ready.

---
 rtl/ram_stream_reader.sv | 226 ++++++++++++++++++++++
 tb/tb_ram_stream_reader.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_stream_reader.sv
// ram_stream_reader
//   Read-side controller for a true-dual-port block RAM. On a start command
//   it reads len words starting at start_addr, wrapping modulo RAM_LEN, and
//   presents them as a valid/ready stream with last-beat marking. The RAM's
//   1-cycle read latency is absorbed by a 2-entry output FIFO, so the block
//   sustains one beat per clock under continuous ready.
//
//   Optional feature (macro RAM_STREAM_READER_REPEAT_EN): adds input stop.
//   The frame is replayed back to back from the latched start_addr/len until
//   stop is seen; the frame in progress then completes and the block ends
//   through DONE. Without the macro the block is single-shot.
//
// Ports
//   clk         single clock; the RAM read port runs on it
//   rst_n       synchronous active-low reset
//   start       frame request, sampled only in IDLE
//   start_addr  first RAM address of the frame
//   len         frame length in words, 0..RAM_LEN
//   stop        (repeat build only) end repetition after the current frame
//   busy        high while a frame is in progress
//   done        one-cycle pulse at frame end
//   ram_en      RAM read enable, high exactly on read-issue cycles
//   ram_addr    RAM read address
//   ram_do      RAM read data, valid the cycle after ram_en
//   m_data      stream data
//   m_valid     stream valid
//   m_ready     stream ready
//   m_last      final beat of the frame, qualified by m_valid

module ram_stream_reader #(
  parameter int ADDRESS_WIDTH = 10,
  parameter int DATA_WIDTH    = 16,
  parameter int RAM_LEN       = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] start_addr,
  input  logic [ADDRESS_WIDTH:0]   len,
`ifdef RAM_STREAM_READER_REPEAT_EN
  input  logic                     stop,
`endif
  output logic                     busy,
  output logic                     done,
  output logic                     ram_en,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0]    ram_do,
  output logic [DATA_WIDTH-1:0]    m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(RAM_LEN - 1);
  localparam logic [ADDRESS_WIDTH:0]   CNT_ONE   = (ADDRESS_WIDTH+1)'(1);

  state_t                  state;
  logic [ADDRESS_WIDTH:0]  rem_issue;   // reads still to issue this pass
  logic [ADDRESS_WIDTH-1:0] rd_ptr;     // next read address
  logic [ADDRESS_WIDTH:0]  beats_left;  // beats still to hand out this frame
  logic                    inflight;    // a read was issued last cycle

  logic [DATA_WIDTH-1:0]   fifo_mem [2];
  logic                    rd_idx;
  logic                    wr_idx;
  logic [1:0]              fifo_count;

`ifdef RAM_STREAM_READER_REPEAT_EN
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [ADDRESS_WIDTH:0]   len_q;
  logic                     stop_seen;
  logic                     stop_any;
  assign stop_any = stop_seen | stop;
`endif

  logic                     pop;
  logic                     last_pop;
  logic                     end_frame;
  logic [2:0]               occ;
  logic [2:0]               occ_limit;
  logic [ADDRESS_WIDTH-1:0] next_ptr;

  assign m_valid  = (fifo_count != 2'd0);
  assign m_data   = fifo_mem[rd_idx];
  assign m_last   = m_valid && (beats_left == CNT_ONE);
  assign ram_addr = rd_ptr;

  assign pop      = m_valid & m_ready;
  assign last_pop = pop & m_last;

  // Entries held plus the read still in flight; a beat leaving this cycle
  // frees one slot, which keeps the pipe full under continuous ready.
  assign occ       = {1'b0, fifo_count} + {2'b00, inflight};
  assign occ_limit = 3'd2 + {2'b00, pop};
  assign ram_en    = (state == S_READ) && (rem_issue != '0) && (occ < occ_limit);

  assign next_ptr = (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + 1'b1;

  // In repeat mode the next pass is already being read while the current
  // one drains, so the frame can also end from READ once stop has been seen.
`ifdef RAM_STREAM_READER_REPEAT_EN
  assign end_frame = last_pop && ((state == S_DRAIN) || ((state == S_READ) && stop_any));
`else
  assign end_frame = last_pop && (state == S_DRAIN);
`endif

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order;
  // later assignments in the block deliberately override earlier ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      rem_issue   <= '0;
      rd_ptr      <= '0;
      beats_left  <= '0;
      inflight    <= 1'b0;
      // NOTE: the two FIFO words are reset (unlike a RAM array) so m_data
      // reads zero out of reset.
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      rd_idx      <= 1'b0;
      wr_idx      <= 1'b0;
      fifo_count  <= 2'd0;
`ifdef RAM_STREAM_READER_REPEAT_EN
      addr_q      <= '0;
      len_q       <= '0;
      stop_seen   <= 1'b0;
`endif
    end else begin
      // Read data returns one cycle after issue and lands in the FIFO.
      inflight <= ram_en;
      if (inflight) begin
        fifo_mem[wr_idx] <= ram_do;
        wr_idx           <= ~wr_idx;
      end
      if (pop) begin
        rd_idx     <= ~rd_idx;
        beats_left <= beats_left - 1'b1;
      end
      fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};

      if (ram_en) begin
        rd_ptr    <= next_ptr;
        rem_issue <= rem_issue - 1'b1;
      end

`ifdef RAM_STREAM_READER_REPEAT_EN
      if (busy) stop_seen <= stop_any;
`endif

      case (state)
        S_IDLE: begin
          if (start) begin
            rd_ptr     <= start_addr;
            rem_issue  <= len;
            beats_left <= len;
`ifdef RAM_STREAM_READER_REPEAT_EN
            addr_q     <= start_addr;
            len_q      <= len;
            stop_seen  <= 1'b0;
`endif
            if (len == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_READ;
              busy  <= 1'b1;
            end
          end
        end

        S_READ: begin
          if (ram_en && (rem_issue == CNT_ONE)) begin
`ifdef RAM_STREAM_READER_REPEAT_EN
            // Reload straight after the final read of a pass so the next
            // pass follows without a bubble.
            if (!stop_any) begin
              rd_ptr    <= addr_q;
              rem_issue <= len_q;
            end else begin
              state <= S_DRAIN;
            end
`else
            state <= S_DRAIN;
`endif
          end
`ifdef RAM_STREAM_READER_REPEAT_EN
          if (last_pop && !stop_any) beats_left <= len_q;
`endif
        end

        S_DRAIN: begin
          // Frame completion is handled by end_frame below.
        end

        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase

      // Reads issued ahead for a pass that will not be emitted are dropped.
      if (end_frame) begin
        state      <= S_DONE;
        busy       <= 1'b0;
        done       <= 1'b1;
        fifo_count <= 2'd0;
        inflight   <= 1'b0;
        rd_idx     <= 1'b0;
        wr_idx     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader: directed cases from the
// functional description followed by randomized frames, all checked against
// a queue-based reference of the expected address and beat streams.

module tb_ram_stream_reader;

  localparam int AW      = 10;
  localparam int DW      = 16;
  localparam int RAM_LEN = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   len = '0;
  logic          busy;
  logic          done;
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_do = '0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic          m_last;
`ifdef RAM_STREAM_READER_REPEAT_EN
  logic          stop = 1'b1;
`endif

  ram_stream_reader #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH   (DW),
    .RAM_LEN      (RAM_LEN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .start_addr(start_addr),
    .len       (len),
`ifdef RAM_STREAM_READER_REPEAT_EN
    .stop      (stop),
`endif
    .busy      (busy),
    .done      (done),
    .ram_en    (ram_en),
    .ram_addr  (ram_addr),
    .ram_do    (ram_do),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Block RAM with registered read, no output register.
  logic [DW-1:0] ram [RAM_LEN];
  always @(posedge clk) if (ram_en) ram_do <= ram[ram_addr];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: expected beats and read addresses of the current frame.
  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int    addr_q[$];
  bit    frame_on = 0;
  int    frame_e0 = 0;
  int    flen = 0;
  int    issued = 0;
  int    popped = 0;

  // Per-frame observations.
  int            en_cnt, first_en, last_en_cyc, first_en_addr, last_en_addr;
  int            beat_cnt, first_beat, last_beat, stall_cnt;
  logic [DW-1:0] last_data;
  int            done_cnt, done_cyc;
  bit            done_seen;

  // Monitor state.
  bit            mon_pop;
  beat_t         mon_e;
  bit            prev_stall = 0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  int ready_mode = 0;  // 0: always ready, 1: 1,0,0,1 pattern, 2: random

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       m_ready = (((cyc - frame_e0 + 2) & 3) == 0) || (((cyc - frame_e0 + 2) & 3) == 3);
        2:       m_ready = ($urandom_range(0, 3) != 0);
        default: m_ready = 1'b1;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      mon_pop = m_valid && m_ready;

      // A read must be issued whenever reads remain and the output side has
      // room for it, and never otherwise.
      if (frame_on && cyc >= frame_e0)
        check("ram_en_rule", ram_en, (issued < flen) && ((issued - popped - int'(mon_pop)) < 2));

      if (ram_en) begin
        if (en_cnt == 0) begin
          first_en      = cyc;
          first_en_addr = int'(ram_addr);
        end
        en_cnt++;
        last_en_cyc  = cyc;
        last_en_addr = int'(ram_addr);
        issued++;
        check("ram_addr_expected", addr_q.size() != 0, 1);
        if (addr_q.size() != 0) check("ram_addr", ram_addr, addr_q.pop_front());
      end

      if (prev_stall) begin
        stall_cnt++;
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, prev_data);
        check("hold_last", m_last, prev_last);
      end

      if (m_valid) check("valid_expected", exp_q.size() != 0, 1);

      if (mon_pop && exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("m_data", m_data, mon_e.data);
        check("m_last", m_last, mon_e.last);
        if (beat_cnt == 0) first_beat = cyc;
        beat_cnt++;
        last_beat = cyc;
        last_data = m_data;
        popped++;
      end

      if (done) begin
        done_cnt++;
        done_cyc  = cyc;
        done_seen = 1;
        check("busy_low_in_done", busy, 0);
      end

      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end else begin
      prev_stall = 0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue a start and load the model with passes x n expected beats.
  task automatic start_frame(input int addr, input int n, input int passes);
    beat_t b;
    en_cnt    = 0;
    beat_cnt  = 0;
    stall_cnt = 0;
    done_cnt  = 0;
    done_seen = 0;
    issued    = 0;
    popped    = 0;
    flen      = n * passes;
    frame_e0  = cyc + 1;
    frame_on  = 1;
    for (int p = 0; p < passes; p++) begin
      for (int k = 0; k < n; k++) begin
        int a;
        a = (addr + k) % RAM_LEN;
        b.data = ram[a];
        b.last = (k == n - 1);
        exp_q.push_back(b);
        addr_q.push_back(a);
      end
    end
    start      = 1'b1;
    start_addr = AW'(addr);
    len        = (AW+1)'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done_seen && n < budget) begin
      tick();
      n++;
    end
    check("done_within_budget", done_seen, 1);
    check("model_drained", exp_q.size(), 0);
  endtask

  task automatic apply_reset(input int cycles);
    rst_n    = 1'b0;
    frame_on = 0;
    exp_q.delete();
    addr_q.delete();
    repeat (cycles) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ram_en", ram_en, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_m_data", m_data, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int n;
    for (int i = 0; i < RAM_LEN; i++) ram[i] = DW'(i);

    apply_reset(2);

    // Basic frame at full throughput.
    ready_mode = 0;
    tick();
    start_frame(0, 8, 1);
    e0 = frame_e0;
    wait_done(40);
    check("t1_first_en", first_en, e0);
    check("t1_last_en", last_en_cyc, e0 + 7);
    check("t1_en_cnt", en_cnt, 8);
    check("t1_first_beat", first_beat, e0 + 2);
    check("t1_last_beat", last_beat, e0 + 9);
    check("t1_beats", beat_cnt, 8);
    check("t1_last_data", last_data, 7);
    check("t1_done_cyc", done_cyc, e0 + 10);
    check("t1_done_cnt", done_cnt, 1);

    // Address wrap at the top of the RAM.
    start_frame(1020, 6, 1);
    wait_done(40);
    check("t2_first_addr", first_en_addr, 1020);
    check("t2_last_addr", last_en_addr, 1);
    check("t2_beats", beat_cnt, 6);
    check("t2_last_data", last_data, 1);

    // Backpressure with ready 1,0,0,1,... from the first beat.
    ready_mode = 1;
    start_frame(100, 4, 1);
    e0 = frame_e0;
    wait_done(60);
    check("t3_beats", beat_cnt, 4);
    check("t3_en_cnt", en_cnt, 4);
    check("t3_last_en", last_en_cyc, e0 + 5);
    check("t3_last_beat", last_beat, e0 + 9);
    check("t3_stalls", stall_cnt, 4);
    check("t3_last_data", last_data, 103);
    ready_mode = 0;

    // Zero-length frame.
    start_frame(5, 0, 1);
    e0 = frame_e0;
    wait_done(10);
    check("t4_done_cyc", done_cyc, e0);
    check("t4_beats", beat_cnt, 0);
    check("t4_en_cnt", en_cnt, 0);

    // Start right after the done pulse; a second start mid-frame is ignored.
    ready_mode = 2;
    start_frame(200, 16, 1);
    repeat (5) tick();
    start      = 1'b1;
    start_addr = AW'(7);
    len        = (AW+1)'(3);
    tick();
    start = 1'b0;
    wait_done(200);
    check("t5_beats", beat_cnt, 16);
    check("t5_en_cnt", en_cnt, 16);
    check("t5_done_cnt", done_cnt, 1);

    // Reset while beat 5 is on the bus, then a fresh frame.
    ready_mode = 0;
    start_frame(300, 16, 1);
    n = 0;
    while (beat_cnt < 4 && n < 40) begin
      tick();
      n++;
    end
    check("t6_reached_beat5", beat_cnt, 4);
    apply_reset(1);
    start_frame(40, 3, 1);
    wait_done(40);
    check("t6_beats", beat_cnt, 3);
    check("t6_last_data", last_data, 42);

    // Randomized frames over random RAM contents.
    for (int i = 0; i < RAM_LEN; i++) ram[i] = DW'($urandom);
    ready_mode = 2;
    for (int f = 0; f < 25; f++) begin
      n = (f == 5) ? RAM_LEN : $urandom_range(0, 40);
      start_frame($urandom_range(0, RAM_LEN - 1), n, 1);
      wait_done(n * 8 + 50);
      check("rnd_beats", beat_cnt, n);
      check("rnd_en_cnt", en_cnt, n);
      check("rnd_done_cnt", done_cnt, 1);
      repeat ($urandom_range(0, 3)) tick();
    end

`ifdef RAM_STREAM_READER_REPEAT_EN
    // Repeated frame with stop pulsed during the second pass.
    for (int i = 0; i < RAM_LEN; i++) ram[i] = DW'(i);
    ready_mode = 0;
    stop = 1'b0;
    tick();
    start_frame(10, 3, 2);
    e0 = frame_e0;
    repeat (5) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_done(40);
    check("rep_beats", beat_cnt, 6);
    check("rep_first_beat", first_beat, e0 + 2);
    check("rep_last_beat", last_beat, e0 + 7);
    check("rep_en_cnt", en_cnt, 6);
    check("rep_done_cyc", done_cyc, e0 + 8);
    check("rep_last_data", last_data, 12);
    stop = 1'b1;
`endif

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
